// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the IF/ID payload type.
package mips_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] ILLEGAL_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new payload, flush to a bubble, or hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // A flush keeps pc_plus4 so the last real PC+4 stays visible downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      q.instr    <= NOP_WORD;
      q.pc_plus4 <= '0;
      q.valid    <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP_WORD;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, samples the memory word into IF/ID, and handles
// stalls, redirects with flush, and sticky fetch faults.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD     = mips_pkg::NOP_WORD,
  parameter logic [31:0] ILLEGAL_WORD = mips_pkg::ILLEGAL_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectTarget,
  output logic [WORD_W-1:0] Address,
  input  logic [WORD_W-1:0] Word,
  output logic [WORD_W-1:0] IfIdInstr,
  output logic [WORD_W-1:0] IfIdPcPlus4,
  output logic              IfIdValid,
  output logic              Halted
);

  logic [WORD_W-1:0] pc, pc_next, pc_plus4;
  fetch_state_t      state, state_next;
  logic              load, flush;
  if_id_t            if_id_d, if_id_q;

  assign pc_plus4 = pc + PC_STEP;

  always_comb begin
    pc_next    = pc;
    state_next = state;
    load       = 1'b0;
    flush      = 1'b0;
    if (state == HALT) begin
      flush = 1'b1;
    end else if (Redirect) begin
      // Wrong-path Word is never inspected on a redirect, only the target alignment.
      flush = 1'b1;
      if (RedirectTarget[1:0] != 2'b00) state_next = HALT;
      else                              pc_next    = RedirectTarget;
    end else if (Stall) begin
      pc_next = pc;
    end else if (Word == ILLEGAL_WORD) begin
      flush      = 1'b1;
      state_next = HALT;
    end else begin
      load    = 1'b1;
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= FETCH;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  assign if_id_d = '{instr: Word, pc_plus4: pc_plus4, valid: 1'b1};

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .flush(flush),
    .d    (if_id_d),
    .q    (if_id_q)
  );

  assign Address     = pc;
  assign Halted      = (state == HALT);
  assign IfIdInstr   = if_id_q.instr;
  assign IfIdPcPlus4 = if_id_q.pc_plus4;
  assign IfIdValid   = if_id_q.valid;

endmodule
